// File: rtl/instr_fifo.sv
// Instruction staging register plus first-word-fall-through queue feeding the TPU control unit.
// Three 32-bit writes assemble an 80-bit instruction; the third write commits it to the queue.
module instr_fifo #(
  parameter int INSTR_WIDTH = 80,
  parameter int FIFO_DEPTH  = 32,
  parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [1:0]             wr_sel,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strb,
  input  logic                   ovf_clear,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [CNT_WIDTH-1:0]   fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow,
  output logic [INSTR_WIDTH-1:0] staged,
  output logic [31:0]            issued_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

  function automatic logic [31:0] merge_word32(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Word2 only carries bits 79:64, so upper strobes and data are dropped here.
  function automatic logic [15:0] merge_word16(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  strb);
    logic [15:0] res;
    res = old_w;
    for (int b = 0; b < 2; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [INSTR_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [INSTR_WIDTH-1:0] staged_q, staged_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            issued_q, issued_d;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    staged_d = staged_q;
    if (wr_en) begin
      case (wr_sel)
        2'd1:    staged_d[31:0]  = merge_word32(staged_q[31:0], wr_data, wr_strb);
        2'd2:    staged_d[63:32] = merge_word32(staged_q[63:32], wr_data, wr_strb);
        2'd3:    staged_d[79:64] = merge_word16(staged_q[79:64], wr_data[15:0], wr_strb[1:0]);
        default: staged_d = staged_q;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a full queue still accepts a commit alongside it.
  always_comb begin
    push_req = wr_en && (wr_sel == 2'd3);
    pop      = !empty_q && instr_ready;
    push_ok  = push_req && (!full_q || pop);
    drop     = push_req && !push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);

    if (drop)           overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
    else                overflow_d = overflow_q;

    issued_d = issued_q + {31'd0, push_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      staged_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      issued_q   <= '0;
    end else begin
      staged_q   <= staged_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      issued_q   <= issued_d;
    end
  end

  // Queue storage carries data only and is never cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= staged_d;
  end

  assign instr_data  = mem_q[rd_ptr_q];
  assign instr_valid = !empty_q;
  assign fifo_count  = count_q;
  assign fifo_full   = full_q;
  assign fifo_empty  = empty_q;
  assign overflow    = overflow_q;
  assign staged      = staged_q;
  assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_instr_fifo.sv
// Directed and random stimulus for instr_fifo, checked against a queue-based reference model.
module tb_instr_fifo;
  localparam int DEPTH = 32;
  localparam int W     = 80;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          ovf_clear;
  logic [W-1:0]  instr_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow;
  logic [W-1:0]  staged;
  logic [31:0]   issued_cnt;

  always #5 clk = ~clk;

  instr_fifo #(.INSTR_WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_strb(wr_strb), .ovf_clear(ovf_clear), .instr_data(instr_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .staged(staged), .issued_cnt(issued_cnt)
  );

  logic [W-1:0] m_q[$];
  logic [W-1:0] m_staged;
  bit           m_ovf;
  int unsigned  m_issued;
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  W'(instr_valid), W'(m_q.size() != 0));
    chk({tag, ".count"},  W'(fifo_count),  W'(m_q.size()));
    chk({tag, ".full"},   W'(fifo_full),   W'(m_q.size() == DEPTH));
    chk({tag, ".empty"},  W'(fifo_empty),  W'(m_q.size() == 0));
    chk({tag, ".ovf"},    W'(overflow),    W'(m_ovf));
    chk({tag, ".staged"}, staged,          m_staged);
    chk({tag, ".issued"}, W'(issued_cnt),  W'(m_issued));
    if (m_q.size() != 0) chk({tag, ".data"}, instr_data, m_q[0]);
  endtask

  // Reference: bytes land in the selected word; a word2 write pushes the merged instruction.
  task automatic model_update(input bit r, input bit we, input logic [1:0] sel,
                              input logic [31:0] d, input logic [3:0] s,
                              input bit rdy, input bit oc);
    bit is_pop, is_push, accept;
    int nbytes;
    if (r) begin
      m_q.delete();
      m_staged = '0;
      m_ovf = 0;
      m_issued = 0;
      return;
    end
    if (we && sel != 0) begin
      nbytes = (sel == 3) ? 2 : 4;
      for (int b = 0; b < nbytes; b++)
        if (s[b]) m_staged[32*(int'(sel)-1) + 8*b +: 8] = d[8*b +: 8];
    end
    is_pop  = (m_q.size() > 0) && rdy;
    is_push = we && sel == 3;
    accept  = is_push && (m_q.size() < DEPTH || is_pop);
    if (is_pop) void'(m_q.pop_front());
    if (accept) begin
      m_q.push_back(m_staged);
      m_issued++;
    end
    if (is_push && !accept) m_ovf = 1;
    else if (oc) m_ovf = 0;
  endtask

  task automatic step(input string tag, input bit r, input bit we, input logic [1:0] sel,
                      input logic [31:0] d, input logic [3:0] s, input bit rdy, input bit oc);
    rst = r; wr_en = we; wr_sel = sel; wr_data = d; wr_strb = s;
    instr_ready = rdy; ovf_clear = oc;
    model_update(r, we, sel, d, s, rdy, oc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 0, 0, 2'd0, 32'h0, 4'h0, rdy, 0);
  endtask

  initial begin
    m_staged = '0; m_ovf = 0; m_issued = 0;

    step("reset0", 1, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", W'(instr_valid), '0);
    chk("reset_empty", W'(fifo_empty), W'(1));
    chk("reset_staged", staged, '0);

    // First commit with the consumer stalled.
    step("w0_zero", 0, 1, 2'd1, 32'h0, 4'hF, 0, 0);
    step("w1_zero", 0, 1, 2'd2, 32'h0, 4'hF, 0, 0);
    step("commit8", 0, 1, 2'd3, 32'h8, 4'hF, 0, 0);
    chk("commit8_data", instr_data, 80'h0008_00000000_00000000);
    chk("commit8_count", W'(fifo_count), W'(1));
    chk("commit8_issued", W'(issued_cnt), W'(1));

    // Byte-enable merge and ignored upper half of word2.
    step("w0_affe", 0, 1, 2'd1, 32'hAFFEDEAD, 4'hF, 0, 0);
    step("w0_strb", 0, 1, 2'd1, 32'h12345678, 4'b0101, 0, 0);
    chk("strb_merge", W'(staged[31:0]), W'(32'hAF34DE78));
    step("commit1234", 0, 1, 2'd3, 32'hFFFF1234, 4'hF, 0, 0);
    chk("word2_bits", W'(staged[79:64]), W'(16'h1234));
    chk("commit1234_count", W'(fifo_count), W'(2));
    for (int i = 0; i < 3; i++) idle("drain_a", 1);
    chk("drain_a_empty", W'(fifo_empty), W'(1));

    // Fill to full, overflow on the 33rd commit, then clear.
    step("rst_fill", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step("fill", 0, 1, 2'd3, $urandom, 4'h3, 0, 0);
    chk("full_flag", W'(fifo_full), W'(1));
    chk("full_count", W'(fifo_count), W'(32));
    step("drop33", 0, 1, 2'd3, 32'h0000BEEF, 4'h3, 0, 0);
    chk("drop_ovf", W'(overflow), W'(1));
    chk("drop_issued", W'(issued_cnt), W'(32));
    step("ovf_clear", 0, 0, 0, 0, 0, 0, 1);
    chk("ovf_cleared", W'(overflow), '0);
    step("drop_vs_clear", 0, 1, 2'd3, 32'h1, 4'h3, 0, 1);
    chk("set_wins", W'(overflow), W'(1));
    step("ovf_clear2", 0, 0, 0, 0, 0, 0, 1);

    // Push and pop together at full, then drain in order.
    step("full_pushpop", 0, 1, 2'd3, 32'h0000CAFE, 4'h3, 1, 0);
    chk("pushpop_count", W'(fifo_count), W'(32));
    chk("pushpop_ovf", W'(overflow), '0);
    for (int i = 0; i < 34; i++) idle("drain_full", 1);
    chk("drain_full_empty", W'(fifo_empty), W'(1));

    // Reset in the middle of a drain discards everything.
    for (int i = 0; i < 3; i++) step("q3", 0, 1, 2'd3, $urandom, 4'hF, 0, 0);
    idle("pop1", 1);
    step("mid_rst", 1, 0, 0, 0, 0, 1, 0);
    chk("mid_rst_count", W'(fifo_count), '0);
    chk("mid_rst_staged", staged, '0);
    step("post_rst_commit", 0, 1, 2'd3, 32'h0000_0042, 4'hF, 0, 0);
    chk("post_rst_data", instr_data, 80'h0042_00000000_00000000);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 34; i++) idle("final_drain", 1);
    chk("final_empty", W'(fifo_empty), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instr_fifo.md
Name: instr_fifo

Overview:
- Instruction staging and queueing stage directly downstream of axi_wrapper's control register window (0x90004/0x90008/0x9000C).
- axi_wrapper forwards each accepted 32-bit write to the three instruction words here.
- This block assembles the 80-bit TPU instruction in a staging register.
- A write to the third word commits the assembled instruction into a FWFT FIFO, which the TPU control unit drains with a valid/ready handshake.

Parameters:
- INSTR_WIDTH, 80: instruction width; word0 = bits 31:0, word1 = 63:32, word2[15:0] = 79:64.
- FIFO_DEPTH, 32: number of queued instructions; power of two, ≥2.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle write strobe from axi_wrapper.
- wr_sel  in  2  target word: 1 = word0 (0x90004), 2 = word1 (0x90008), 3 = word2 + commit (0x9000C); 0 = ignored.
- wr_data  in  32  write data.
- wr_strb  in  4  byte enables.
- ovf_clear  in  1  clears the sticky overflow flag.
- instr_data  out  INSTR_WIDTH  instruction at FIFO head.
- instr_valid  out  1  FIFO not empty.
- instr_ready  in  1  consumer accepts head.
- fifo_count  out  CNT_WIDTH  current occupancy.
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- overflow  out  1  sticky: a commit was dropped.
- staged  out  INSTR_WIDTH  staging register contents (for readback).
- issued_cnt  out  32  total instructions accepted into FIFO; wraps at 2^32.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Staging register, read/write pointers, fifo_count, overflow and issued_cnt all go to 0.
  - Resulting outputs: instr_valid=0, fifo_empty=1, fifo_full=0.
  - FIFO storage need not be cleared; instr_data is don't-care while instr_valid=0.
- Mid-operation reset: the in-progress partial instruction and all queued entries are discarded.
- Byte-enable writes:
  - Applied only when wr_en=1 and wr_sel≠0.
  - Each byte with wr_strb[b]=1 updates the corresponding byte of the selected staging word; other bytes are held.
  - For wr_sel=3, only bytes 0–1 (bits 79:64) exist; strb[3:2] and data[31:16] are ignored.
- Commit:
  - A wr_sel=3 write pushes the merged value: staging word0/word1 plus word2 as updated by this cycle's data/strobes.
  - The staging register keeps the merged value after commit; it is not cleared, so repeated commits re-issue the same instruction.
- Push acceptance:
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the instruction is dropped, overflow is set to 1, and the staging update still happens.
- Pop: occurs when instr_valid=1 and instr_ready=1 at a rising edge.
- Simultaneous push and pop:
  - fifo_count is unchanged and both pointers advance.
  - When the FIFO is empty, only the push happens, since no pop is possible.
- Latency:
  - A committed instruction is visible on instr_data with instr_valid=1 one cycle after the commit edge.
  - After a pop, the next entry appears on the following cycle.
- Ordering: strict FIFO.
- Pointers: log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
- Status flags fifo_full, fifo_empty and fifo_count are registered and consistent with each other in every cycle.
- overflow:
  - Cleared only by rst or by ovf_clear=1.
  - If ovf_clear and a new drop occur in the same cycle, the set wins (overflow=1).
- issued_cnt increments by 1 on every accepted push.
- instr_ready while empty is ignored: no pointer movement, no underflow.

Test Plan:
- Reset, then check outputs → instr_valid=0, fifo_empty=1, fifo_count=0, overflow=0, issued_cnt=0, staged=0.
- Write word0=0x00000000 and word1=0x00000000, then commit word2=0x00000008 (strb 1111) with instr_ready=0 → next cycle instr_valid=1, instr_data=0x0008_00000000_00000000, fifo_count=1, issued_cnt=1.
- Starting from staged word0=0xAFFEDEAD:
  - Write word0=0x12345678 with strb=0101 → staged[31:0]=0xAF34DE78.
  - Commit word2=0xFFFF1234 → bits 79:64 = 0x1234; data[31:16] ignored.
- Commit 33 times with instr_ready=0 (DEPTH 32):
  - After 32 commits → fifo_full=1, count=32.
  - 33rd commit → dropped, overflow=1, issued_cnt=32.
  - Pulse ovf_clear → overflow=0.
- With the FIFO full, commit and pop in the same cycle → accepted, count stays 32, overflow stays 0. Then drain all entries → order matches push order exactly and fifo_empty=1 at the end.
- Queue 3 entries, assert rst mid-drain → next cycle count=0, instr_valid=0, staged=0. A subsequent commit works normally.
